shifter_pipe: RTL

Two-stage pipelined, width-parametrised ARM shifter-operand unit with valid/ready handshake. It produces the data-processing operand and its carry-out from one of three sources:

- an 8-bit immediate, rotated;
- Rm shifted by an immediate amount;
- Rm shifted by a register amount.

It sits between decode and the ALU and supersedes the combinational operand mux.

---
 rtl/shifter_pipe_if.sv | 48 ++++
 rtl/shifter_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe_if.sv
// ---------------------------------------------------------------------------------------------
// shifter_pipe_if: request/response bundle for the ARM shifter-operand pipeline.
//
// Parameters
//   DATA_W  operand width (power of two, 16..64)
//   AMT_W   width of the immediate shift amount, $clog2(DATA_W)
//
// Signals
//   in_valid / in_ready          request handshake
//   sel, shift_type              operand source and shift kind
//   imm8, rotate_imm             immediate value and rotate amount / 2
//   shift_imm                    immediate shift amount
//   rm, rs, c_in                 value to shift, register amount (rs[7:0]), current C flag
//   out_valid / out_ready        result handshake
//   shifter_operand              result
//   shifter_carry_out            carry result
//
// Modports: master drives requests and accepts results, slave is the shifter.
// ---------------------------------------------------------------------------------------------
interface shifter_pipe_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned AMT_W  = $clog2(DATA_W)
);
   logic              in_valid;
   logic              in_ready;
   logic [1:0]        sel;
   logic [1:0]        shift_type;
   logic [7:0]        imm8;
   logic [3:0]        rotate_imm;
   logic [AMT_W-1:0]  shift_imm;
   logic [DATA_W-1:0] rm;
   logic [DATA_W-1:0] rs;
   logic              c_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] shifter_operand;
   logic              shifter_carry_out;

   modport master (
      output in_valid, sel, shift_type, imm8, rotate_imm, shift_imm, rm, rs, c_in, out_ready,
      input  in_ready, out_valid, shifter_operand, shifter_carry_out
   );

   modport slave (
      input  in_valid, sel, shift_type, imm8, rotate_imm, shift_imm, rm, rs, c_in, out_ready,
      output in_ready, out_valid, shifter_operand, shifter_carry_out
   );
endinterface

// File: rtl/shifter_pipe.sv
// ---------------------------------------------------------------------------------------------
// shifter_pipe: two-stage pipelined ARM shifter-operand unit with valid/ready handshake.
//
// Stage 1 latches the request already decoded into {value, kind, amount, full/over flags}.
// Stage 2 runs the barrel shift and registers the operand and carry.
//
// Ports
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   io_bus  shifter_pipe_if.slave (request fields, handshakes, operand and carry out)
//
// Configuration
//   SHIFTER_REG_SHIFT_EN  when defined, sel=10 shifts rm by rs[7:0]; when undefined sel=10
//                         behaves as pass-through and the 8-bit amount comparators are absent.
// ---------------------------------------------------------------------------------------------
module shifter_pipe #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned AMT_W  = $clog2(DATA_W)
) (
   input logic            clk,
   input logic            rst_n,
   shifter_pipe_if.slave  io_bus
);

   typedef enum logic [2:0] {
      KindPass,
      KindLsl,
      KindLsr,
      KindAsr,
      KindRor,
      KindRrx
   } kind_e;

   localparam logic [1:0] SelImmRot   = 2'b00;
   localparam logic [1:0] SelImmShift = 2'b01;
`ifdef SHIFTER_REG_SHIFT_EN
   localparam logic [1:0] SelRegShift = 2'b10;
`endif
   localparam logic [1:0] ShLsl = 2'b00;
   localparam logic [1:0] ShLsr = 2'b01;
   localparam logic [1:0] ShAsr = 2'b10;

   // ------------------------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------------------------
   logic w_s2_load;
   logic w_s1_load;
   logic w_accept;
   logic r_s1_valid;
   logic r_s2_valid;

   assign w_s2_load = !r_s2_valid || io_bus.out_ready;
   assign w_s1_load = !r_s1_valid || w_s2_load;
   assign w_accept  = io_bus.in_valid && w_s1_load;

   // ------------------------------------------------------------------------------------------
   // Stage 1 decode
   // ------------------------------------------------------------------------------------------
   logic [DATA_W-1:0] w_dec_val;
   kind_e             w_dec_kind;
   logic [AMT_W-1:0]  w_dec_amt;
   logic              w_dec_full;
   logic              w_dec_over;
   logic [4:0]        w_rot2;
   logic              w_imm_zero;

   assign w_rot2     = {io_bus.rotate_imm, 1'b0};
   assign w_imm_zero = (io_bus.shift_imm == '0);

`ifdef SHIFTER_REG_SHIFT_EN
   logic [7:0] w_rs_amt;
   logic       w_unused_rs;

   assign w_rs_amt    = io_bus.rs[7:0];
   assign w_unused_rs = ^io_bus.rs[DATA_W-1:8];
`else
   logic w_unused_rs;

   assign w_unused_rs = ^io_bus.rs;
`endif

   // full: amount equals DATA_W exactly; over: amount exceeds DATA_W. Only the shift kinds
   // look at them; ROR uses the low AMT_W bits, which is already the amount mod DATA_W.
   always_comb begin
      w_dec_val  = io_bus.rm;
      w_dec_kind = KindPass;
      w_dec_amt  = io_bus.shift_imm;
      w_dec_full = 1'b0;
      w_dec_over = 1'b0;
      unique case (io_bus.sel)
         SelImmRot: begin
            w_dec_val = DATA_W'(io_bus.imm8);
            w_dec_amt = AMT_W'(w_rot2);
            if (io_bus.rotate_imm != 4'd0) w_dec_kind = KindRor;
         end
         SelImmShift: begin
            unique case (io_bus.shift_type)
               ShLsl: if (!w_imm_zero) w_dec_kind = KindLsl;
               // LSR/ASR #0 encode a shift by DATA_W
               ShLsr: begin
                  w_dec_kind = KindLsr;
                  w_dec_full = w_imm_zero;
               end
               ShAsr: begin
                  w_dec_kind = KindAsr;
                  w_dec_full = w_imm_zero;
               end
               default: w_dec_kind = w_imm_zero ? KindRrx : KindRor;
            endcase
         end
`ifdef SHIFTER_REG_SHIFT_EN
         SelRegShift: begin
            w_dec_amt  = w_rs_amt[AMT_W-1:0];
            w_dec_full = (w_rs_amt == 8'(DATA_W));
            w_dec_over = (w_rs_amt > 8'(DATA_W));
            if (w_rs_amt != 8'd0) begin
               unique case (io_bus.shift_type)
                  ShLsl:   w_dec_kind = KindLsl;
                  ShLsr:   w_dec_kind = KindLsr;
                  ShAsr:   w_dec_kind = KindAsr;
                  default: w_dec_kind = KindRor;
               endcase
            end
         end
`endif
         default: ;  // pass-through: rm, c_in
      endcase
   end

   logic [DATA_W-1:0] r_s1_val;
   kind_e             r_s1_kind;
   logic [AMT_W-1:0]  r_s1_amt;
   logic              r_s1_full;
   logic              r_s1_over;
   logic              r_s1_cin;

   // ------------------------------------------------------------------------------------------
   // Stage 2 barrel shift
   // ------------------------------------------------------------------------------------------
   logic [DATA_W:0]   w_lsl;
   logic [DATA_W:0]   w_lsr;
   logic [DATA_W:0]   w_asr;
   logic [AMT_W:0]    w_ror_back;
   logic [DATA_W-1:0] w_ror;
   logic [DATA_W-1:0] w_res;
   logic              w_carry;

   // The extra bit on each shift catches the last bit shifted out, i.e. the carry.
   assign w_lsl      = {1'b0, r_s1_val} << r_s1_amt;
   assign w_lsr      = {r_s1_val, 1'b0} >> r_s1_amt;
   assign w_asr      = $signed({r_s1_val, 1'b0}) >>> r_s1_amt;
   assign w_ror_back = (AMT_W + 1)'(DATA_W) - {1'b0, r_s1_amt};
   assign w_ror      = (r_s1_val >> r_s1_amt) | (r_s1_val << w_ror_back);

   always_comb begin
      w_res   = r_s1_val;
      w_carry = r_s1_cin;
      unique case (r_s1_kind)
         KindLsl: begin
            if (r_s1_over) begin
               w_res   = '0;
               w_carry = 1'b0;
            end else if (r_s1_full) begin
               w_res   = '0;
               w_carry = r_s1_val[0];
            end else begin
               {w_carry, w_res} = w_lsl;
            end
         end
         KindLsr: begin
            if (r_s1_over) begin
               w_res   = '0;
               w_carry = 1'b0;
            end else if (r_s1_full) begin
               w_res   = '0;
               w_carry = r_s1_val[DATA_W-1];
            end else begin
               {w_res, w_carry} = w_lsr;
            end
         end
         KindAsr: begin
            if (r_s1_over || r_s1_full) begin
               w_res   = {DATA_W{r_s1_val[DATA_W-1]}};
               w_carry = r_s1_val[DATA_W-1];
            end else begin
               {w_res, w_carry} = w_asr;
            end
         end
         // Carry of any non-trivial rotate is the bit that lands in the MSB.
         KindRor: begin
            w_res   = w_ror;
            w_carry = w_ror[DATA_W-1];
         end
         KindRrx: begin
            w_res   = {r_s1_cin, r_s1_val[DATA_W-1:1]};
            w_carry = r_s1_val[0];
         end
         default: ;
      endcase
   end

   logic [DATA_W-1:0] r_s2_operand;
   logic              r_s2_carry;

   // ------------------------------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid   <= 1'b0;
         r_s1_val     <= '0;
         r_s1_kind    <= KindPass;
         r_s1_amt     <= '0;
         r_s1_full    <= 1'b0;
         r_s1_over    <= 1'b0;
         r_s1_cin     <= 1'b0;
         r_s2_valid   <= 1'b0;
         r_s2_operand <= '0;
         r_s2_carry   <= 1'b0;
      end else begin
         if (w_s1_load) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
               r_s1_val  <= w_dec_val;
               r_s1_kind <= w_dec_kind;
               r_s1_amt  <= w_dec_amt;
               r_s1_full <= w_dec_full;
               r_s1_over <= w_dec_over;
               r_s1_cin  <= io_bus.c_in;
            end
         end
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            // Keep the last result when a bubble moves in so the outputs stay quiet.
            if (r_s1_valid) begin
               r_s2_operand <= w_res;
               r_s2_carry   <= w_carry;
            end
         end
      end
   end

   assign io_bus.in_ready          = w_s1_load;
   assign io_bus.out_valid         = r_s2_valid;
   assign io_bus.shifter_operand   = r_s2_operand;
   assign io_bus.shifter_carry_out = r_s2_carry;

endmodule
